score_keeper: RTL

Game-side score producer for fpga-bird. It counts pipe-pass events during play, saturates at a configurable maximum, and tracks the session high score. It drives the 32-bit binary score bus consumed by the score display block. It also exports the same value as two BCD digits, so downstream logic needs no divider.

---
 rtl/score_keeper.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/score_keeper.sv
// score_keeper: round score counter for fpga-bird with saturation, BCD
// digits and a session high score.
//
// Ports:
//   clk        system clock
//   resetn     asynchronous active-low reset
//   start      one-cycle pulse: begin or restart a round
//   pass_pipe  level, high while the bird is inside a pipe gap; the rising edge scores
//   collide    one-cycle pulse: bird hit a pipe or the ground
//   score      current round score, binary, 0..MAX_SCORE (upper 25 bits zero)
//   high_score best final score since reset, binary
//   tens       BCD tens digit of score
//   ones       BCD ones digit of score
//   new_high   one-cycle pulse when high_score is updated
//   game_state 0 = IDLE, 1 = PLAY, 2 = OVER
module score_keeper #(
  parameter int unsigned MAX_SCORE = 99
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        pass_pipe,
  input  logic        collide,
  output logic [31:0] score,
  output logic [31:0] high_score,
  output logic [3:0]  tens,
  output logic [3:0]  ones,
  output logic        new_high,
  output logic [1:0]  game_state
);

  localparam int unsigned SCORE_W = 7;
  localparam int unsigned BUS_W   = 32;
  localparam int unsigned DIGIT_W = 4;
  // Values above the two-digit display range are clamped to 99.
  localparam int unsigned SAT     = (MAX_SCORE > 99) ? 99 : MAX_SCORE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_OVER = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [SCORE_W-1:0]   score_q, score_d;
  logic [SCORE_W-1:0]   high_q, high_d;
  logic [DIGIT_W-1:0]   tens_q, tens_d;
  logic [DIGIT_W-1:0]   ones_q, ones_d;
  logic                 new_high_q, new_high_d;
  logic                 pass_q;
  logic                 inc_ev;
  logic                 at_max;

  // Scoring edge: collide in the same cycle suppresses it.
  assign inc_ev = pass_pipe & ~pass_q & ~collide;
  assign at_max = (score_q == SCORE_W'(SAT));

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= ST_IDLE;
      score_q    <= '0;
      high_q     <= '0;
      tens_q     <= '0;
      ones_q     <= '0;
      new_high_q <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      score_q    <= score_d;
      high_q     <= high_d;
      tens_q     <= tens_d;
      ones_q     <= ones_d;
      new_high_q <= new_high_d;
      pass_q     <= pass_pipe;
    end
  end

  // Next-state, score arithmetic and high-score update.
  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    tens_d     = tens_q;
    ones_d     = ones_q;
    new_high_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        score_d = '0;
        tens_d  = '0;
        ones_d  = '0;
        if (start) begin
          state_d = ST_PLAY;
        end
      end

      ST_PLAY: begin
        if (collide) begin
          state_d = ST_OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end
        end else if (inc_ev && !at_max) begin
          score_d = score_q + SCORE_W'(1);
          // Binary and BCD advance together so score == 10*tens + ones.
          if (ones_q == DIGIT_W'(9)) begin
            ones_d = '0;
            tens_d = tens_q + DIGIT_W'(1);
          end else begin
            ones_d = ones_q + DIGIT_W'(1);
          end
        end
      end

      ST_OVER: begin
        if (start) begin
          state_d = ST_PLAY;
          score_d = '0;
          tens_d  = '0;
          ones_d  = '0;
        end
      end

      default: begin
        // Unreachable encoding: recover to a clean idle.
        state_d = ST_IDLE;
        score_d = '0;
        tens_d  = '0;
        ones_d  = '0;
      end
    endcase
  end

  assign score      = BUS_W'(score_q);
  assign high_score = BUS_W'(high_q);
  assign tens       = tens_q;
  assign ones       = ones_q;
  assign new_high   = new_high_q;
  assign game_state = state_q;

endmodule
